// File: rtl/rx_ctrl_pkg.sv
// Shared types for the UART RX FIFO controller.
//   rd_state_t : read-side FSM state
//   level_w()  : width of the occupancy counter for a given FIFO depth. It must
//                hold FIFO_DEPTH+1 (a full FIFO plus the byte on the stream).
package rx_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        VALID = 2'd2
    } rd_state_t;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int LEVEL_W = level_w(16);

endpackage

// File: rtl/rx_timeout_timer.sv
// Receive-timeout timer. It counts baud ticks while bytes are waiting and
// raises a sticky interrupt once TIMEOUT_TICKS ticks have gone by with no
// receive or consume activity.
//   CLKi  system clock          RSTi  async active-low reset
//   TICKi baud-tick strobe      CLRi  restart count and clear TOo
//   ENi   count enable          TOo   sticky timeout flag
module rx_timeout_timer #(
    parameter int TIMEOUT_TICKS = 32
) (
    input  logic CLKi,
    input  logic RSTi,
    input  logic TICKi,
    input  logic CLRi,
    input  logic ENi,
    output logic TOo
);

    localparam int CW = $clog2(TIMEOUT_TICKS + 1);

    logic [CW-1:0] cnt_q;
    logic          hit;

    assign hit = (cnt_q == CW'(TIMEOUT_TICKS));

    always_ff @(posedge CLKi or negedge RSTi) begin
        if (!RSTi) begin
            cnt_q <= '0;
            TOo   <= 1'b0;
        end else if (CLRi) begin
            cnt_q <= '0;
            TOo   <= 1'b0;
        end else begin
            // The count saturates, so the flag stays set until the next clear.
            if (TICKi && ENi && !hit)
                cnt_q <= cnt_q + 1'b1;
            if (hit && ENi)
                TOo <= 1'b1;
        end
    end

endmodule

// File: rtl/rx_fifo_ctrl.sv
// Sequencing controller between the UART RX deserializer and the byte FIFO.
// On the write side it blocks writes to a full FIFO. On the read side it
// turns the FIFO's registered read into a valid/ready stream. It also keeps
// the occupancy level, the sticky overflow flag, the watermark IRQ and the
// optional receive-timeout IRQ. The timeout IRQ is built only when the macro
// RX_FIFO_CTRL_TIMEOUT_EN is defined.
//   CLKi/RSTi            clock, async active-low reset
//   RX_VALIDi/RX_DATAi   received byte pulse
//   TICKi                baud tick (timeout only)
//   F_WEo/F_DATAo        FIFO write port
//   F_RDo/F_DATAi        FIFO read enable, registered read data
//   F_FULLi/F_EMPTYi     FIFO flags
//   M_VALIDo/M_DATAo/M_READYi  output stream
//   LEVELo               bytes not yet accepted by the consumer
//   OVFo/OVF_CLRi        sticky overflow flag and its clear
//   IRQ_WMo/IRQ_TOo      watermark and timeout interrupts
module rx_fifo_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int WM_LEVEL      = 8,
    parameter int TIMEOUT_TICKS = 32
) (
    input  logic                        CLKi,
    input  logic                        RSTi,
    input  logic                        RX_VALIDi,
    input  logic [DATA_WIDTH-1:0]       RX_DATAi,
    input  logic                        TICKi,
    output logic                        F_WEo,
    output logic [DATA_WIDTH-1:0]       F_DATAo,
    output logic                        F_RDo,
    input  logic [DATA_WIDTH-1:0]       F_DATAi,
    input  logic                        F_FULLi,
    input  logic                        F_EMPTYi,
    output logic                        M_VALIDo,
    output logic [DATA_WIDTH-1:0]       M_DATAo,
    input  logic                        M_READYi,
    output logic [$clog2(FIFO_DEPTH):0] LEVELo,
    output logic                        OVFo,
    input  logic                        OVF_CLRi,
    output logic                        IRQ_WMo,
    output logic                        IRQ_TOo
);

    localparam int LW = level_w(FIFO_DEPTH);

    rd_state_t     state_q;
    logic          rd_q;
    logic          vld_q;
    logic [LW-1:0] level_q;
    logic          accept;

    // The FIFO pointers do not guard against overflow, so writes are gated here.
    assign F_WEo   = RX_VALIDi & ~F_FULLi;
    assign F_DATAo = RX_DATAi;

    // The FIFO output register holds its value between reads, so the stream
    // data stays stable under back-pressure without a local copy.
    assign M_DATAo  = F_DATAi;
    assign M_VALIDo = vld_q;
    assign F_RDo    = rd_q;
    assign accept   = vld_q & M_READYi;

    // F_RDo and M_VALIDo are registered together with the state. The FIFO has
    // no other reader, so it cannot go empty between IDLE/VALID and RD.
    always_ff @(posedge CLKi or negedge RSTi) begin
        if (!RSTi) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (!F_EMPTYi) begin
                    state_q <= RD;
                    rd_q    <= 1'b1;
                end
                RD: begin
                    state_q <= VALID;
                    rd_q    <= 1'b0;
                    vld_q   <= 1'b1;
                end
                VALID: if (M_READYi) begin
                    vld_q <= 1'b0;
                    if (!F_EMPTYi) begin
                        state_q <= RD;
                        rd_q    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rd_q    <= 1'b0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    // The level counts the FIFO contents plus the byte held on the stream.
    always_ff @(posedge CLKi or negedge RSTi) begin
        if (!RSTi)
            level_q <= '0;
        else if (F_WEo && !accept)
            level_q <= level_q + LW'(1);
        else if (!F_WEo && accept)
            level_q <= level_q - LW'(1);
    end

    // When set and clear arrive together, the set takes priority.
    always_ff @(posedge CLKi or negedge RSTi) begin
        if (!RSTi)
            OVFo <= 1'b0;
        else if (RX_VALIDi && F_FULLi)
            OVFo <= 1'b1;
        else if (OVF_CLRi)
            OVFo <= 1'b0;
    end

    assign LEVELo  = level_q;
    assign IRQ_WMo = (level_q >= LW'(WM_LEVEL));

`ifdef RX_FIFO_CTRL_TIMEOUT_EN
    rx_timeout_timer #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_timeout (
        .CLKi  (CLKi),
        .RSTi  (RSTi),
        .TICKi (TICKi),
        .CLRi  (RX_VALIDi | accept),
        .ENi   (level_q != '0),
        .TOo   (IRQ_TOo)
    );
`else
    logic unused_tick;
    assign unused_tick = TICKi;
    assign IRQ_TOo     = 1'b0;
`endif

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
module tb_rx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid, tick, m_ready, ovf_clr;
    logic [7:0] rx_data;
    logic       f_we, f_rd, f_full, f_empty;
    logic [7:0] f_wdata, f_rdata, m_data;
    logic       m_valid, ovf, irq_wm, irq_to;
    logic [4:0] level;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q [$];

`ifdef RX_FIFO_CTRL_TIMEOUT_EN
    localparam logic EXP_TO = 1'b1;
`else
    localparam logic EXP_TO = 1'b0;
`endif

    always #5 clk = ~clk;

    rx_fifo_ctrl #(
        .DATA_WIDTH(8), .FIFO_DEPTH(16), .WM_LEVEL(8), .TIMEOUT_TICKS(32)
    ) dut (
        .CLKi(clk), .RSTi(rst_n), .RX_VALIDi(rx_valid), .RX_DATAi(rx_data),
        .TICKi(tick), .F_WEo(f_we), .F_DATAo(f_wdata), .F_RDo(f_rd),
        .F_DATAi(f_rdata), .F_FULLi(f_full), .F_EMPTYi(f_empty),
        .M_VALIDo(m_valid), .M_DATAo(m_data), .M_READYi(m_ready),
        .LEVELo(level), .OVFo(ovf), .OVF_CLRi(ovf_clr),
        .IRQ_WMo(irq_wm), .IRQ_TOo(irq_to)
    );

    // Unguarded 16-deep FIFO with registered read data, like the real one.
    logic [7:0] mem [16];
    logic [3:0] wp, rp;
    logic [4:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0; rp <= '0; cnt <= '0; f_rdata <= '0;
        end else begin
            if (f_we) begin mem[wp] <= f_wdata; wp <= wp + 4'd1; end
            if (f_rd) begin f_rdata <= mem[rp]; rp <= rp + 4'd1; end
            cnt <= cnt + {4'b0, f_we} - {4'b0, f_rd};
        end
    end
    assign f_full  = (cnt == 5'd16);
    assign f_empty = (cnt == 5'd0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor and FIFO protocol checks.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {24'b0, m_data}, 32'hFFFF_FFFF);
            end else begin
                chk("stream_data", {24'b0, m_data}, {24'b0, exp_q.pop_front()});
            end
        end
        if (rst_n && (f_we || f_rd)) begin
            chk("no_wr_full", {31'b0, f_we & f_full}, 0);
            chk("no_rd_empty", {31'b0, f_rd & f_empty}, 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input logic keep, input logic clr = 1'b0);
        rx_valid = 1'b1; rx_data = b; ovf_clr = clr;
        if (keep) exp_q.push_back(b);
        @(negedge clk);
        chk("f_we", {31'b0, f_we}, {31'b0, keep});
        chk("f_data", {24'b0, f_wdata}, {24'b0, b});
        @(posedge clk); #1;
        rx_valid = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) cyc(1);
        chk("drain_done", exp_q.size(), 0);
        cyc(2);
        chk("drain_level", {27'b0, level}, 0);
        chk("drain_valid", {31'b0, m_valid}, 0);
        m_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tick = 1'b0;
        m_ready = 1'b0; ovf_clr = 1'b0;
        cyc(3);
        chk("rst_we", {31'b0, f_we}, 0);
        chk("rst_rd", {31'b0, f_rd}, 0);
        chk("rst_valid", {31'b0, m_valid}, 0);
        chk("rst_level", {27'b0, level}, 0);
        chk("rst_ovf", {31'b0, ovf}, 0);
        chk("rst_wm", {31'b0, irq_wm}, 0);
        chk("rst_to", {31'b0, irq_to}, 0);
        chk("rst_mdata", {24'b0, m_data}, 0);
        rst_n = 1'b1;
        cyc(2);

        // Single byte: a 3-cycle latency from RX_VALIDi to M_VALIDo.
        m_ready = 1'b1;
        wr(8'hA5, 1'b1);
        chk("sb_level1", {27'b0, level}, 1);
        chk("sb_valid_c1", {31'b0, m_valid}, 0);
        cyc(1);
        chk("sb_rd_c2", {31'b0, f_rd}, 1);
        chk("sb_valid_c2", {31'b0, m_valid}, 0);
        cyc(1);
        chk("sb_valid_c3", {31'b0, m_valid}, 1);
        chk("sb_data_c3", {24'b0, m_data}, 32'hA5);
        cyc(1);
        chk("sb_level0", {27'b0, level}, 0);
        chk("sb_valid_c4", {31'b0, m_valid}, 0);

        // Fill with no consumer. Byte 0x00 moves to VALID, so 17 fit.
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr(8'(i), 1'b1);
            chk("fill_level", {27'b0, level}, i + 1);
            chk("fill_wm", {31'b0, irq_wm}, {31'b0, (i + 1) >= 8});
        end
        wr(8'h10, 1'b1);
        chk("peak_level", {27'b0, level}, 17);
        chk("ovf_before", {31'b0, ovf}, 0);
        wr(8'h11, 1'b0);
        chk("ovf_set", {31'b0, ovf}, 1);
        chk("ovf_level", {27'b0, level}, 17);
        wr(8'h12, 1'b0, 1'b1);
        chk("ovf_set_wins", {31'b0, ovf}, 1);
        ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
        chk("ovf_clr", {31'b0, ovf}, 0);

        // Back-pressure: the stream holds byte 0x00 and issues no reads.
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'b0, m_valid}, 1);
            chk("bp_data", {24'b0, m_data}, 0);
            chk("bp_rd", {31'b0, f_rd}, 0);
            cyc(1);
        end
        drain();
        chk("wm_after_drain", {31'b0, irq_wm}, 0);

        // Write and accept in the same cycle.
        wr(8'h31, 1'b1); wr(8'h32, 1'b1); wr(8'h33, 1'b1);
        cyc(3);
        chk("sim_level3", {27'b0, level}, 3);
        chk("sim_valid", {31'b0, m_valid}, 1);
        m_ready = 1'b1;
        wr(8'h34, 1'b1);
        m_ready = 1'b0;
        chk("sim_level_hold", {27'b0, level}, 3);
        drain();

        // Timeout with one byte held.
        wr(8'h5A, 1'b1);
        cyc(3);
        for (int i = 0; i < 32; i++) begin
            tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
            if (i == 30) chk("to_31", {31'b0, irq_to}, 0);
        end
        cyc(1);
        chk("to_32", {31'b0, irq_to}, {31'b0, EXP_TO});
        m_ready = 1'b1; cyc(1); m_ready = 1'b0;
        chk("to_clr", {31'b0, irq_to}, 0);
        cyc(2);
        chk("to_level0", {27'b0, level}, 0);

        // Reset mid-stream with 5 bytes outstanding.
        for (int i = 0; i < 5; i++) wr(8'h41 + 8'(i), 1'b1);
        cyc(3);
        chk("mid_level5", {27'b0, level}, 5);
        chk("mid_valid", {31'b0, m_valid}, 1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_level", {27'b0, level}, 0);
        chk("mid_rst_valid", {31'b0, m_valid}, 0);
        chk("mid_rst_rd", {31'b0, f_rd}, 0);
        chk("mid_rst_ovf", {31'b0, ovf}, 0);
        chk("mid_rst_wm", {31'b0, irq_wm}, 0);
        chk("mid_rst_mdata", {24'b0, m_data}, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("post_rst_valid", {31'b0, m_valid}, 0);
        chk("post_rst_rd", {31'b0, f_rd}, 0);
        chk("post_rst_level", {27'b0, level}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
